// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic pipeline stage register with a valid/ready handshake.
// It has a 2-entry skid buffer (head + skid). Because in_ready and out_valid are
// decoded from registered state only, in_ready never depends combinationally on
// out_ready. A flush empties the stage and drives BUBBLE_VAL on out_data.
// Optional feature macro: PIPE_STATS_EN adds saturating stall/flush counters
// (stall_cnt, flush_cnt) of width CNT_W.
module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
`ifdef PIPE_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  logic push;
  logic pop;

  // Handshake outputs come straight from the registered occupancy.
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_TWO);
  assign out_data  = head_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Next-state and datapath selection; flush overrides any push/pop.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      // A concurrent push is dropped; a concurrent pop already completed downstream.
      state_d = ST_EMPTY;
      head_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            head_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_d = in_data;
          end else if (push) begin
            skid_d  = in_data;
            state_d = ST_TWO;
          end else if (pop) begin
            head_d  = BUBBLE_VAL;
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            head_d  = skid_q;
            skid_d  = BUBBLE_VAL;
            state_d = ST_ONE;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty stage.
          state_d = ST_EMPTY;
          head_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  // State and storage registers with synchronous reset to an empty stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      head_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating statistics counters; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed testbench for pipe_stage_skid (DATA_W=16, non-zero bubble value).
// Inputs change 1 time unit after a rising edge; outputs are checked at that
// same point, i.e. they reflect the edge just taken.
module tb_pipe_stage_skid;

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] BUBBLE = 16'hDEAD;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STATS_EN
  logic [3:0]        stall_cnt;
  logic [3:0]        flush_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  pipe_stage_skid #(
    .DATA_W    (DATA_W),
    .BUBBLE_VAL(BUBBLE)
`ifdef PIPE_STATS_EN
    ,
    .CNT_W     (4)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef PIPE_STATS_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
    $display("[TB] %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Checks the full handshake/output triple in one go.
  task automatic chk_out(input string tag, input logic v, input logic r, input logic [DATA_W-1:0] d);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, r});
    chk({tag, ".out_data"},  {16'd0, out_data},  {16'd0, d});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 16'h1111; out_ready = 1'b0;
    // Reset wins over a simultaneous push.
    step(); step();
    chk_out("reset", 1'b0, 1'b1, BUBBLE);
    rst = 1'b0; in_valid = 1'b0;

    // 1: back-to-back A,B,C with out_ready=1, one-cycle latency.
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 16'h00A1; step(); chk_out("t1_A", 1'b1, 1'b1, 16'h00A1);
    in_data = 16'h00B2; step(); chk_out("t1_B", 1'b1, 1'b1, 16'h00B2);
    in_data = 16'h00C3; step(); chk_out("t1_C", 1'b1, 1'b1, 16'h00C3);
    in_valid = 1'b0;    step(); chk_out("t1_drain", 1'b0, 1'b1, BUBBLE);

    // 2: backpressure fills skid, then drains in order.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'h0A0A; step(); chk_out("t2_oneA", 1'b1, 1'b1, 16'h0A0A);
    in_data = 16'h0B0B; step(); chk_out("t2_twoAB", 1'b1, 1'b0, 16'h0A0A);
    in_data = 16'h0C0C; step(); chk_out("t2_hold", 1'b1, 1'b0, 16'h0A0A);
    in_valid = 1'b0; out_ready = 1'b1;
    step(); chk_out("t2_popA", 1'b1, 1'b1, 16'h0B0B);
    step(); chk_out("t2_popB", 1'b0, 1'b1, BUBBLE);

    // 3: flush in TWO with a concurrent push of C.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'h3A3A; step();
    in_data = 16'h3B3B; step(); chk_out("t3_two", 1'b1, 1'b0, 16'h3A3A);
    in_data = 16'h3C3C; flush = 1'b1;
    step(); chk_out("t3_flush", 1'b0, 1'b1, BUBBLE);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); chk_out("t3_noC", 1'b0, 1'b1, BUBBLE);

    // 4: push&pop in ONE replaces head with no bubble.
    in_valid = 1'b1; in_data = 16'h4A4A;
    step(); chk_out("t4_one", 1'b1, 1'b1, 16'h4A4A);
    in_data = 16'h4D4D;
    step(); chk_out("t4_D", 1'b1, 1'b1, 16'h4D4D);
    in_valid = 1'b0;
    step(); chk_out("t4_empty", 1'b0, 1'b1, BUBBLE);

    // 5: reset while in TWO discards both entries.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'h5A5A; step();
    in_data = 16'h5B5B; step(); chk_out("t5_two", 1'b1, 1'b0, 16'h5A5A);
    in_valid = 1'b0; rst = 1'b1;
    step(); chk_out("t5_rst", 1'b0, 1'b1, BUBBLE);
    rst = 1'b0; out_ready = 1'b1;
    step(); chk_out("t5_after", 1'b0, 1'b1, BUBBLE);

`ifdef PIPE_STATS_EN
    // 6: counters clear on reset, stall saturates at 15, flush counts when empty.
    chk("t6_stall_rst", {28'd0, stall_cnt}, 32'd0);
    chk("t6_flush_rst", {28'd0, flush_cnt}, 32'd0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h6666;
    step(); in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("t6_stall5", {28'd0, stall_cnt}, 32'd5);
    for (int i = 0; i < 15; i++) step();
    chk("t6_stall_sat", {28'd0, stall_cnt}, 32'd15);
    flush = 1'b1;
    for (int i = 0; i < 3; i++) step();
    flush = 1'b0;
    step();
    chk("t6_flush3", {28'd0, flush_cnt}, 32'd3);
    chk("t6_stall_hold", {28'd0, stall_cnt}, 32'd15);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
